// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: per-pin pad synchronizer followed by a consecutive-cycle debounce filter feeding gpio_i.
// Optional registered edge pulses are built when GPIO_DEBOUNCE_EDGE_EN is defined.
module gpio_in_debounce #(
  parameter int NUM_GPIO        = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_GPIO-1:0] gpio_pad_i,
  input  logic [NUM_GPIO-1:0] db_en,
`ifdef GPIO_DEBOUNCE_EDGE_EN
  output logic [NUM_GPIO-1:0] gpio_redge_o,
  output logic [NUM_GPIO-1:0] gpio_fedge_o,
`endif
  output logic [NUM_GPIO-1:0] gpio_db_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_GPIO-1:0] sync_r [SYNC_STAGES];
  logic [NUM_GPIO-1:0] sync_s;
  logic [CW-1:0]       cnt_r     [NUM_GPIO];
  logic [CW-1:0]       cnt_nxt_s [NUM_GPIO];
  logic [NUM_GPIO-1:0] db_r;
  logic [NUM_GPIO-1:0] db_nxt_s;

  // Synchronizer chain: plain flop-to-flop, nothing between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {NUM_GPIO{1'b0}};
      end
    end else begin
      sync_r[0] <= gpio_pad_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Per-pin filter decision; the counter only runs while the pin disagrees with its output.
  always_comb begin
    db_nxt_s = db_r;
    for (int i = 0; i < NUM_GPIO; i++) begin
      cnt_nxt_s[i] = CNT_ZERO;
      if (!db_en[i]) begin
        db_nxt_s[i] = sync_s[i];
      end else if (sync_s[i] == db_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_LAST) begin
        db_nxt_s[i] = sync_s[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Filter state registers: counters and the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r <= {NUM_GPIO{1'b0}};
      for (int i = 0; i < NUM_GPIO; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      db_r <= db_nxt_s;
      for (int i = 0; i < NUM_GPIO; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign gpio_db_o = db_r;

`ifdef GPIO_DEBOUNCE_EDGE_EN
  logic [NUM_GPIO-1:0] gpio_db_last_r;
  logic [NUM_GPIO-1:0] redge_r;
  logic [NUM_GPIO-1:0] fedge_r;

  // Edge pulses registered one cycle behind the debounced level; reset keeps last==cur so no pulse on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_db_last_r <= {NUM_GPIO{1'b0}};
      redge_r        <= {NUM_GPIO{1'b0}};
      fedge_r        <= {NUM_GPIO{1'b0}};
    end else begin
      gpio_db_last_r <= db_r;
      redge_r        <= db_r & ~gpio_db_last_r;
      fedge_r        <= ~db_r & gpio_db_last_r;
    end
  end

  assign gpio_redge_o = redge_r;
  assign gpio_fedge_o = fedge_r;
`endif

endmodule
